mul_share_arbiter: RTL and testbench

Shares one fixed-latency FP16 multiplier datapath (unpack, mantissa product, normalizer) between two requesters, e.g. the FP MAC lane and the INT/FP conversion path. It accepts operand pairs over valid/ready handshakes and grants round-robin at one issue per cycle. It registers the granted operands onto the multiplier inputs and tracks each in-flight operation with a tag shift register, so every product returns to the requester that issued it. It holds no product data; the result bus passes straight through.

---
 rtl/mul_share_if.sv | 40 ++++
 rtl/mul_share_arbiter.sv | 76 +++++++
 tb/tb_mul_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_if.sv
// Bundle of the signals between two requesters, the shared multiplier and the arbiter.
// The slave modport is the arbiter side. The master modport is the requester/multiplier side.
interface mul_share_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             mul_valid;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_res;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_res,
        output req0_ready, req1_ready,
        output mul_valid, mul_a, mul_b,
        output rsp0_valid, rsp1_valid, rsp_data, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_res,
        input  req0_ready, req1_ready,
        input  mul_valid, mul_a, mul_b,
        input  rsp0_valid, rsp1_valid, rsp_data, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency FP16 multiplier between two requesters.
// A tag pipe, aligned with the multiplier latency, routes each result back to the requester that issued it.
module mul_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int LAT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    mul_share_if.slave bus
);
    logic             last_grant_q, last_grant_d;
    logic             grant0, grant1;
    logic             mul_valid_q, mul_valid_d;
    logic             mul_id_q, mul_id_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [LAT-1:0]   tag_valid_q, tag_valid_d;
    logic [LAT-1:0]   tag_id_q, tag_id_d;

    // When both requesters are valid, the one that was not granted last wins.
    always_comb begin
        grant0 = en & bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = en & bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        mul_valid_d  = grant0 | grant1;
        mul_id_d     = grant1;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        if (grant0) begin
            last_grant_d = 1'b0;
            mul_a_d      = bus.req0_a;
            mul_b_d      = bus.req0_b;
        end else if (grant1) begin
            last_grant_d = 1'b1;
            mul_a_d      = bus.req1_a;
            mul_b_d      = bus.req1_b;
        end
        // The operand register is tag stage zero. LAT more stages line up with mul_res.
        tag_valid_d = (tag_valid_q << 1) | LAT'(mul_valid_q);
        tag_id_d    = (tag_id_q << 1) | LAT'(mul_id_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            mul_valid_q  <= 1'b0;
            mul_id_q     <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            tag_valid_q  <= '0;
            tag_id_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            mul_valid_q  <= mul_valid_d;
            mul_id_q     <= mul_id_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            tag_valid_q  <= tag_valid_d;
            tag_id_q     <= tag_id_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mul_valid  = mul_valid_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.rsp0_valid = tag_valid_q[LAT-1] & ~tag_id_q[LAT-1];
    assign bus.rsp1_valid = tag_valid_q[LAT-1] & tag_id_q[LAT-1];
    assign bus.rsp_data   = bus.mul_res;
    assign bus.busy       = mul_valid_q | (|tag_valid_q);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Three arbiters (LAT = 3, 1 and 8) receive the same directed stimulus.
// Each arbiter feeds a fake multiplier. A transaction-level model is compared against every output on every cycle.
module tb_mul_share_arbiter;
    localparam int W  = 16;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [15:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat_of[NI] = '{3, 1, 8};

    logic        rdy0_w[NI], rdy1_w[NI], mv_w[NI], r0_w[NI], r1_w[NI], busy_w[NI];
    logic [15:0] ma_w[NI], mb_w[NI], rd_w[NI];

    // Reference FP16 multiply for normal operands, with the mantissa truncated.
    function automatic logic [15:0] fp16mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] p;
        int          e;
        logic [9:0]  m;
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LATV = (gi == 0) ? 3 : ((gi == 1) ? 1 : 8);
        mul_share_if #(.WIDTH(W)) ifc ();
        logic [15:0] pipe [LATV];

        assign ifc.req0_valid = v0;
        assign ifc.req0_a     = a0;
        assign ifc.req0_b     = b0;
        assign ifc.req1_valid = v1;
        assign ifc.req1_a     = a1;
        assign ifc.req1_b     = b1;
        assign ifc.mul_res    = pipe[LATV-1];

        // Fake multiplier with no reset. It outputs random data when no operation is valid.
        always @(posedge clk) begin
            pipe[0] <= ifc.mul_valid ? fp16mul(ifc.mul_a, ifc.mul_b) : 16'($urandom);
            for (int k = 1; k < LATV; k++) pipe[k] <= pipe[k-1];
        end

        mul_share_arbiter #(.WIDTH(W), .LAT(LATV)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .bus   (ifc)
        );

        assign rdy0_w[gi] = ifc.req0_ready;
        assign rdy1_w[gi] = ifc.req1_ready;
        assign mv_w[gi]   = ifc.mul_valid;
        assign ma_w[gi]   = ifc.mul_a;
        assign mb_w[gi]   = ifc.mul_b;
        assign r0_w[gi]   = ifc.rsp0_valid;
        assign r1_w[gi]   = ifc.rsp1_valid;
        assign rd_w[gi]   = ifc.rsp_data;
        assign busy_w[gi] = ifc.busy;
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        int          due;
        logic        id;
        logic [15:0] prod;
    } op_t;

    op_t         exp_q [NI][$];
    logic        m_ptr = 1'b1;
    logic        m_mv = 1'b0;
    logic [15:0] m_ma = '0, m_mb = '0;
    int          cyc = 0;
    int          m_g;

    // Returns the requester granted this cycle, or -1 when no requester is granted.
    function automatic int model_grant();
        if (!en) return -1;
        if (v0 && v1) return (m_ptr == 1'b1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   = 0;
            m_ptr = 1'b1;
            m_mv  = 1'b0;
            m_ma  = '0;
            m_mb  = '0;
            for (int i = 0; i < NI; i++) exp_q[i].delete();
        end else begin
            m_g = model_grant();
            cyc = cyc + 1;
            if (m_g >= 0) begin
                m_ptr = (m_g == 1);
                m_mv  = 1'b1;
                m_ma  = (m_g == 0) ? a0 : a1;
                m_mb  = (m_g == 0) ? b0 : b1;
                for (int i = 0; i < NI; i++)
                    exp_q[i].push_back('{due: cyc + lat_of[i], id: (m_g == 1), prod: fp16mul(m_ma, m_mb)});
            end else begin
                m_mv = 1'b0;
            end
            for (int i = 0; i < NI; i++)
                while (exp_q[i].size() > 0 && exp_q[i][0].due < cyc) void'(exp_q[i].pop_front());
        end
    end

    // ---------------- checking (single process) ----------------
    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s inst%0d: actual %0h required %0h (time %0t)", nm, inst, act, req, $time);
        end
    endtask

    int          tcyc = 0;
    int          rsp0_cnt[NI], rsp1_cnt[NI], busy_cnt[NI], first_mv[NI], first_rsp[NI];
    logic [15:0] first_ma[NI], first_mb[NI], first_rd[NI];
    int          grant_trace[$], rsp_trace[$];
    int          first_rdy0;
    logic        last_rdy0, last_rdy1;

    task automatic clear_obs();
        for (int i = 0; i < NI; i++) begin
            rsp0_cnt[i] = 0; rsp1_cnt[i] = 0; busy_cnt[i] = 0;
            first_mv[i] = -1; first_rsp[i] = -1;
            first_ma[i] = '0; first_mb[i] = '0; first_rd[i] = '0;
        end
        grant_trace.delete();
        rsp_trace.delete();
        first_rdy0 = -1;
    endtask

    task automatic compare_all();
        int   g;
        logic er0, er1;
        g = model_grant();
        for (int i = 0; i < NI; i++) begin
            er0 = exp_q[i].size() > 0 && exp_q[i][0].due == cyc && exp_q[i][0].id == 1'b0;
            er1 = exp_q[i].size() > 0 && exp_q[i][0].due == cyc && exp_q[i][0].id == 1'b1;
            chk("req0_ready", i, 32'(rdy0_w[i]), 32'(g == 0));
            chk("req1_ready", i, 32'(rdy1_w[i]), 32'(g == 1));
            chk("mul_valid", i, 32'(mv_w[i]), 32'(m_mv));
            chk("mul_a", i, 32'(ma_w[i]), 32'(m_ma));
            chk("mul_b", i, 32'(mb_w[i]), 32'(m_mb));
            chk("rsp0_valid", i, 32'(r0_w[i]), 32'(er0));
            chk("rsp1_valid", i, 32'(r1_w[i]), 32'(er1));
            chk("busy", i, 32'(busy_w[i]), 32'(exp_q[i].size() > 0));
            if (er0 || er1) chk("rsp_data", i, 32'(rd_w[i]), 32'(exp_q[i][0].prod));
        end
    endtask

    task automatic observe();
        for (int i = 0; i < NI; i++) begin
            if (r0_w[i] || r1_w[i]) begin
                if (first_rsp[i] < 0) begin
                    first_rsp[i] = tcyc;
                    first_rd[i]  = rd_w[i];
                end
                if (i == 0) rsp_trace.push_back(r1_w[i] ? 1 : 0);
            end
            if (r0_w[i]) rsp0_cnt[i]++;
            if (r1_w[i]) rsp1_cnt[i]++;
            if (busy_w[i]) busy_cnt[i]++;
            if (mv_w[i] && first_mv[i] < 0) begin
                first_mv[i] = tcyc;
                first_ma[i] = ma_w[i];
                first_mb[i] = mb_w[i];
            end
        end
        if (rdy0_w[0]) grant_trace.push_back(0);
        if (rdy1_w[0]) grant_trace.push_back(1);
        if (rdy0_w[0] && first_rdy0 < 0) first_rdy0 = tcyc;
        last_rdy0 = rdy0_w[0];
        last_rdy1 = rdy1_w[0];
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        observe();
        @(posedge clk);
        #1;
        tcyc++;
        if (last_rdy0) begin a0 = a0 + 16'h0010; b0 = b0 + 16'h0020; end
        if (last_rdy1) begin a1 = a1 + 16'h0030; b1 = b1 + 16'h0008; end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic chk_trace(input string nm, input int got[$], input int req[$]);
        chk({nm, "_len"}, 0, 32'(got.size()), 32'(req.size()));
        for (int k = 0; k < req.size() && k < got.size(); k++)
            chk(nm, 0, 32'(got[k]), 32'(req[k]));
    endtask

    int t0;

    initial begin
        clear_obs();
        // Hand-computed anchors for the reference multiply.
        chk("fp16mul_1.5x2", 0, 32'(fp16mul(16'h3E00, 16'h4000)), 32'h4200);
        chk("fp16mul_-2x0.5", 0, 32'(fp16mul(16'hC000, 16'h3800)), 32'hBC00);

        // Reset state
        run(2);
        rst_n = 1'b1;
        run(1);

        // Single issue
        clear_obs();
        t0 = tcyc;
        en = 1'b1; v0 = 1'b1; a0 = 16'h3E00; b0 = 16'h4000;
        cycle();
        v0 = 1'b0;
        run(12);
        chk("single_ready_cycle", 0, 32'(first_rdy0), 32'(t0));
        for (int i = 0; i < NI; i++) begin
            chk("single_mul_a", i, 32'(first_ma[i]), 32'h3E00);
            chk("single_mul_b", i, 32'(first_mb[i]), 32'h4000);
            chk("single_mv_cycle", i, 32'(first_mv[i]), 32'(t0 + 1));
            chk("single_rsp_offset", i, 32'(first_rsp[i] - first_mv[i]), 32'(lat_of[i]));
            chk("single_rsp_data", i, 32'(first_rd[i]), 32'h4200);
            chk("single_rsp0_count", i, 32'(rsp0_cnt[i]), 32'd1);
            chk("single_rsp1_count", i, 32'(rsp1_cnt[i]), 32'd0);
            chk("single_busy_cycles", i, 32'(busy_cnt[i]), 32'(lat_of[i] + 1));
        end

        // Solo streaming on requester 1, which was not the last requester granted
        clear_obs();
        v1 = 1'b1; a1 = 16'h4100; b1 = 16'h3C80;
        run(4);
        v1 = 1'b0;
        run(12);
        chk_trace("solo_grants", grant_trace, '{1, 1, 1, 1});
        for (int i = 0; i < NI; i++) chk("solo_rsp1_count", i, 32'(rsp1_cnt[i]), 32'd4);

        // Contention: the last grant was to requester 1, so requester 0 wins first
        clear_obs();
        v0 = 1'b1; v1 = 1'b1; a0 = 16'h3C00; b0 = 16'h3D00; a1 = 16'hC200; b1 = 16'h3A00;
        run(6);
        v0 = 1'b0; v1 = 1'b0;
        run(12);
        chk_trace("contention_grants", grant_trace, '{0, 1, 0, 1, 0, 1});
        chk_trace("contention_rsps", rsp_trace, '{0, 1, 0, 1, 0, 1});
        for (int i = 0; i < NI; i++) chk("contention_busy", i, 32'(busy_cnt[i]), 32'(6 + lat_of[i]));

        // Enable gating
        clear_obs();
        v0 = 1'b1; v1 = 1'b1;
        run(2);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(2);
        v0 = 1'b0; v1 = 1'b0;
        run(12);
        chk_trace("engate_grants", grant_trace, '{0, 1, 0, 1});
        for (int i = 0; i < NI; i++) begin
            chk("engate_rsp0_count", i, 32'(rsp0_cnt[i]), 32'd2);
            chk("engate_rsp1_count", i, 32'(rsp1_cnt[i]), 32'd2);
        end

        // Reset while operations are in flight
        v0 = 1'b1; a0 = 16'h4400; b0 = 16'h4200;
        run(3);
        v0 = 1'b0;
        rst_n = 1'b0;
        clear_obs();
        run(2);
        rst_n = 1'b1;
        run(12);
        for (int i = 0; i < NI; i++) begin
            chk("postrst_rsp0_count", i, 32'(rsp0_cnt[i]), 32'd0);
            chk("postrst_rsp1_count", i, 32'(rsp1_cnt[i]), 32'd0);
            chk("postrst_busy", i, 32'(busy_cnt[i]), 32'd0);
            chk("postrst_no_issue", i, 32'(first_mv[i]), 32'hFFFF_FFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
